// File: rtl/miriscv_data_decoder.sv
// miriscv_data_decoder: routes core data requests to N_SLAVES base/mask
// regions and returns responses in issue order.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   m_*              core-side req/gnt/rvalid port
//   s_*              slave-side request (one-hot) and response ports
//   err_count_o      saturating count of granted decode errors
module miriscv_data_decoder #(
    parameter int unsigned                 N_SLAVES   = 2,
    parameter int unsigned                 MAX_OUT    = 2,
    parameter logic [32*N_SLAVES-1:0]      SLAVE_BASE = {32'h0000_1000, 32'h0000_0000},
    parameter logic [32*N_SLAVES-1:0]      SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_FF00},
    parameter logic [31:0]                 ERR_RDATA  = 32'h0000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    m_req_i,
    input  logic                    m_we_i,
    input  logic [3:0]              m_be_i,
    input  logic [31:0]             m_addr_i,
    input  logic [31:0]             m_wdata_i,
    output logic                    m_gnt_o,
    output logic                    m_rvalid_o,
    output logic [31:0]             m_rdata_o,
    output logic                    m_err_o,
    output logic [N_SLAVES-1:0]     s_req_o,
    output logic                    s_we_o,
    output logic [3:0]              s_be_o,
    output logic [31:0]             s_addr_o,
    output logic [31:0]             s_wdata_o,
    input  logic [N_SLAVES-1:0]     s_gnt_i,
    input  logic [N_SLAVES-1:0]     s_rvalid_i,
    input  logic [32*N_SLAVES-1:0]  s_rdata_i,
    output logic [15:0]             err_count_o
);

    localparam int unsigned IDW = $clog2(N_SLAVES + 1);
    localparam int unsigned PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CW  = $clog2(MAX_OUT + 1);
    localparam logic [IDW-1:0] ERR_ID = IDW'(N_SLAVES);

    logic [IDW-1:0] fifo_q [MAX_OUT];
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] last_q;
    logic [15:0]    err_cnt_q, err_cnt_d;

    logic [IDW-1:0] sel;
    logic [IDW-1:0] head;
    logic           sel_gnt;
    logic           full, empty;
    logic           issue, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Descending scan so the lowest matching index wins.
    always_comb begin
        sel = ERR_ID;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])
                sel = IDW'(i);
        end
    end

    // The error target always accepts.
    always_comb begin
        sel_gnt = 1'b1;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel == IDW'(i)) sel_gnt = s_gnt_i[i];
        end
    end

    assign full  = (cnt_q == CW'(MAX_OUT));
    assign empty = (cnt_q == '0);

    // Only stack requests behind the same target so responses cannot reorder.
    assign issue = !rst_i && m_req_i && !full && (empty || sel == last_q);

    assign m_gnt_o = issue && sel_gnt;

    always_comb begin
        s_req_o = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            s_req_o[i] = issue && (sel == IDW'(i));
        end
    end

    assign s_we_o    = m_we_i;
    assign s_be_o    = m_be_i;
    assign s_addr_o  = m_addr_i;
    assign s_wdata_o = m_wdata_i;

    assign head = fifo_q[rptr_q];

    // Responses from anything but the head target are dropped.
    always_comb begin
        m_rvalid_o = 1'b0;
        m_rdata_o  = '0;
        m_err_o    = 1'b0;
        if (!rst_i && !empty) begin
            if (head == ERR_ID) begin
                m_rvalid_o = 1'b1;
                m_rdata_o  = ERR_RDATA;
                m_err_o    = 1'b1;
            end else begin
                for (int i = 0; i < N_SLAVES; i++) begin
                    if (head == IDW'(i)) begin
                        m_rvalid_o = s_rvalid_i[i];
                        m_rdata_o  = s_rdata_i[32*i +: 32];
                    end
                end
            end
        end
    end

    assign push = m_gnt_o;
    assign pop  = m_rvalid_o;

    always_comb begin
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        wptr_d    = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d    = pop  ? ptr_inc(rptr_q) : rptr_q;
        err_cnt_d = err_cnt_q;
        if (push && sel == ERR_ID && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            last_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            err_cnt_q <= err_cnt_d;
            if (push) begin
                fifo_q[wptr_q] <= sel;
                last_q         <= sel;
            end
        end
    end

    assign err_count_o = err_cnt_q;

endmodule

// File: doc/miriscv_data_decoder.md
Name: miriscv_data_decoder

Overview:
- Parametrised data-bus decoder between the core's data port (req/gnt/rvalid protocol) and N_SLAVES memory-mapped targets (RAM, peripherals).
- Generalises the single-RAM address check to N base/mask regions.
- Supports up to MAX_OUT pipelined outstanding transactions, with in-order response routing.
- Returns an error response for unmapped addresses instead of silently dropping them.

Parameters:
- N_SLAVES, 2, number of downstream targets (1..8).
- MAX_OUT, 2, maximum outstanding granted-but-unanswered transactions (power of 2, 1..8).
- SLAVE_BASE, {32'h0000_1000, 32'h0000_0000}, packed N_SLAVES×32 region base addresses; entry i is at bits [32*i +: 32].
- SLAVE_MASK, {32'hFFFF_F000, 32'hFFFF_FF00}, packed N_SLAVES×32 region masks.
- ERR_RDATA, 32'h0000_0000, read data returned on a decode error.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- m_req_i  in  1  master request
- m_we_i  in  1  master write enable
- m_be_i  in  4  master byte enables
- m_addr_i  in  32  master address
- m_wdata_i  in  32  master write data
- m_gnt_o  out  1  request accepted this cycle
- m_rvalid_o  out  1  response valid
- m_rdata_o  out  32  response read data
- m_err_o  out  1  response is a decode error (qualified by m_rvalid_o)
- s_req_o  out  N_SLAVES  per-slave request
- s_we_o  out  1  broadcast write enable
- s_be_o  out  4  broadcast byte enables
- s_addr_o  out  32  broadcast address
- s_wdata_o  out  32  broadcast write data
- s_gnt_i  in  N_SLAVES  per-slave grant
- s_rvalid_i  in  N_SLAVES  per-slave response valid
- s_rdata_i  in  32*N_SLAVES  per-slave read data, packed
- err_count_o  out  16  saturating count of decode errors

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Decode (combinational):
  - Slave i hits when (m_addr_i & MASK[i]) == BASE[i].
  - On overlapping hits, the lowest index wins.
  - No hit selects the internal error target, id = N_SLAVES.
- Order tracker: FIFO of target ids, depth MAX_OUT, with count, read pointer and write pointer.
  - Push on m_req_i && m_gnt_o.
  - Pop on m_rvalid_o.
- Issue condition, allowed only when all of these hold:
  - m_req_i is high;
  - the FIFO is not full (a same-cycle pop does not free a slot);
  - the FIFO is empty, or the selected id equals the most recently pushed id.
  - The last rule prevents cross-slave response reordering.
- Forwarding:
  - s_req_o[sel] = issue condition; all other s_req_o bits are 0.
  - s_we/be/addr/wdata are always a copy of the master inputs.
  - m_gnt_o = issue && s_gnt_i[sel] for a real slave; m_gnt_o = issue for the error target.
- Responses:
  - Let h = FIFO head id.
  - When the FIFO is non-empty and h < N_SLAVES: m_rvalid_o = s_rvalid_i[h], m_rdata_o = s_rdata_i[h], m_err_o = 0.
  - When h == N_SLAVES: m_rvalid_o = 1, m_rdata_o = ERR_RDATA, m_err_o = 1. This gives an error response exactly 1 cycle after the grant when the error entry is at the head.
  - s_rvalid_i from a non-head slave, or while the FIFO is empty, is ignored (dropped).
- Push and pop in the same cycle are legal when not full; count is unchanged.
- err_count_o increments on every granted error-target transaction and holds at 16'hFFFF.
- Reset values:
  - FIFO empty, pointers 0, err_count_o = 0.
  - While rst_i = 1: m_gnt_o = 0, m_rvalid_o = 0, m_err_o = 0, s_req_o = 0, m_rdata_o = 0.
  - Reset mid-transaction discards all outstanding ids; later slave responses are ignored.
- Throughput: 1 transaction per cycle to the same slave, given zero-wait slaves and MAX_OUT ≥ 2.

Test Plan:
- Read at 0x0000_0010, slave 0 grants immediately, rvalid next cycle with 0xA5A5_0001 -> s_req_o = 2'b01; m_gnt_o = 1 in cycle 0; m_rvalid_o = 1, m_rdata_o = 0xA5A5_0001, m_err_o = 0 in cycle 1.
- Back-to-back reads to 0x0000_1000, then 0x0000_0004, with slave 1 answering in 3 cycles -> second request is stalled (s_req_o = 0, m_gnt_o = 0) until slave 1's rvalid pops the FIFO; responses arrive in issue order.
- Write to unmapped address 0x0000_2000 -> m_gnt_o = 1 same cycle; no s_req_o bit set; next cycle m_rvalid_o = 1, m_err_o = 1, m_rdata_o = 0; err_count_o = 1.
- MAX_OUT = 2, three consecutive reads to slave 0, slave grants but withholds rvalid -> third request has m_gnt_o = 0 until the first rvalid.
- Spurious s_rvalid_i[1] while the FIFO is empty -> m_rvalid_o stays 0.
- Assert rst_i with 2 transactions outstanding, then slave rvalid arrives -> m_rvalid_o = 0, FIFO empty, err_count_o = 0.
- Force 65,536 error transactions -> err_count_o holds at 0xFFFF.
